// File: rtl/collision_arbiter.sv
// Per-frame snake-head/object overlap counter with prioritised event handshake, saturating score and sticky game-over.
// One cycle from frame_end or evt_ack to updated outputs; evt_valid holds until acked, and unacked food events block further food.
module collision_arbiter #(
   parameter int                    N_LAYERS    = 4,
   parameter logic [N_LAYERS-1:0]   LETHAL_MASK = 4'b1011,
   parameter int                    MIN_HITS    = 2,
   parameter int                    CNT_W       = 8,
   parameter int                    SCORE_W     = 8,
   parameter int                    LAYER_W     = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pix_valid,
   input  logic                 grn_snake_head,
   input  logic [N_LAYERS-1:0]  red_layer,
   input  logic                 frame_end,
   input  logic                 evt_ack,
   output logic [1:0]           state_o,
   output logic                 evt_valid,
   output logic [LAYER_W-1:0]   evt_layer,
   output logic [SCORE_W-1:0]   score_o,
   output logic                 game_over_o
);

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      EAT  = 2'b01,
      DEAD = 2'b10
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    hit_cnt [N_LAYERS];
   logic [N_LAYERS-1:0] hit;
   logic [N_LAYERS-1:0] lethal_vec;
   logic [N_LAYERS-1:0] food_vec;
   logic [LAYER_W-1:0]  lethal_idx;
   logic [LAYER_W-1:0]  food_idx;
   logic                count_en;
   logic                ack_ok;

   assign count_en = pix_valid & grn_snake_head & ~frame_end & (state != DEAD);
   assign ack_ok   = evt_ack & evt_valid;
   assign state_o  = state;

   always_comb begin
      for (int i = 0; i < N_LAYERS; i++) begin
         hit[i] = 32'(hit_cnt[i]) >= 32'(MIN_HITS);
      end
      lethal_vec = hit & LETHAL_MASK;
      food_vec   = hit & ~LETHAL_MASK;
   end

   // Scan downwards so the lowest set index is the last one written.
   always_comb begin
      lethal_idx = '0;
      food_idx   = '0;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (lethal_vec[i]) lethal_idx = LAYER_W'(i);
         if (food_vec[i])   food_idx   = LAYER_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_LAYERS; i++) begin
         if (reset || frame_end || state == DEAD) begin
            hit_cnt[i] <= '0;
         end else if (count_en && red_layer[i] && hit_cnt[i] != '1) begin
            hit_cnt[i] <= hit_cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         evt_valid   <= 1'b0;
         evt_layer   <= '0;
         score_o     <= '0;
         game_over_o <= 1'b0;
      end else begin
         case (state)
            RUN, EAT: begin
               if (frame_end) begin
                  if (|lethal_vec) begin
                     state       <= DEAD;
                     evt_valid   <= 1'b1;
                     evt_layer   <= lethal_idx;
                     game_over_o <= 1'b1;
                  end else if (state == RUN || ack_ok) begin
                     // An ack arriving with frame_end frees the slot before the frame is judged.
                     if (|food_vec) begin
                        state     <= EAT;
                        evt_valid <= 1'b1;
                        evt_layer <= food_idx;
                        if (score_o != '1) score_o <= score_o + 1'b1;
                     end else begin
                        state     <= RUN;
                        evt_valid <= 1'b0;
                     end
                  end
               end else if (ack_ok) begin
                  state     <= RUN;
                  evt_valid <= 1'b0;
               end
            end
            DEAD: begin
               if (ack_ok) evt_valid <= 1'b0;
            end
            default: begin
               state     <= RUN;
               evt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter: directed scenarios with fixed expectations, then randomized traffic against a frame-level model.
module tb_collision_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_valid = 1'b0;
   logic       grn_snake_head = 1'b0;
   logic [3:0] red_layer = '0;
   logic       frame_end = 1'b0;
   logic       evt_ack = 1'b0;
   logic [1:0] state_o;
   logic       evt_valid;
   logic [1:0] evt_layer;
   logic [7:0] score_o;
   logic       game_over_o;
   logic [1:0] sat_state;
   logic       sat_valid;
   logic [1:0] sat_layer;
   logic [1:0] sat_score;
   logic       sat_go;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   collision_arbiter dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .grn_snake_head(grn_snake_head),
      .red_layer(red_layer), .frame_end(frame_end), .evt_ack(evt_ack),
      .state_o(state_o), .evt_valid(evt_valid), .evt_layer(evt_layer),
      .score_o(score_o), .game_over_o(game_over_o)
   );

   collision_arbiter #(.SCORE_W(2)) u_sat (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .grn_snake_head(grn_snake_head),
      .red_layer(red_layer), .frame_end(frame_end), .evt_ack(evt_ack),
      .state_o(sat_state), .evt_valid(sat_valid), .evt_layer(sat_layer),
      .score_o(sat_score), .game_over_o(sat_go)
   );

   // Frame-level reference: mode 0 playing, 1 food event outstanding, 2 dead.
   int m_mode, m_valid, m_layer, m_score, m_go;
   int m_cnt [4];

   task automatic model_update(input logic pv, input logic hd, input logic [3:0] rl,
                               input logic fe, input logic ack, input logic rst);
      int lethal_at, food_at;
      bit acked;
      if (rst) begin
         m_mode = 0; m_valid = 0; m_layer = 0; m_score = 0; m_go = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         return;
      end
      acked = ack && (m_valid == 1);
      if (m_mode == 2) begin
         if (acked) m_valid = 0;
         return;
      end
      if (fe) begin
         lethal_at = -1; food_at = -1;
         for (int i = 0; i < 4; i++) begin
            if (m_cnt[i] >= 2) begin
               if (i != 2 && lethal_at < 0) lethal_at = i;
               if (i == 2 && food_at < 0)   food_at = i;
            end
         end
         if (lethal_at >= 0) begin
            m_mode = 2; m_valid = 1; m_layer = lethal_at; m_go = 1;
         end else if (m_mode == 0 || acked) begin
            if (food_at >= 0) begin
               m_mode = 1; m_valid = 1; m_layer = food_at;
               m_score = (m_score < 255) ? m_score + 1 : 255;
            end else begin
               m_mode = 0; m_valid = 0;
            end
         end
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
         if (acked) begin m_mode = 0; m_valid = 0; end
         if (pv && hd)
            for (int i = 0; i < 4; i++) if (rl[i] && m_cnt[i] < 255) m_cnt[i]++;
      end
   endtask

   task automatic step(input logic pv, input logic hd, input logic [3:0] rl,
                       input logic fe, input logic ack, input logic rst);
      pix_valid = pv; grn_snake_head = hd; red_layer = rl;
      frame_end = fe; evt_ack = ack; reset = rst;
      @(posedge clk);
      model_update(pv, hd, rl, fe, ack, rst);
      #1;
      pix_valid = 1'b0; frame_end = 1'b0; evt_ack = 1'b0; reset = 1'b0;
   endtask

   task automatic pixels(input logic [3:0] rl, input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, rl, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame(input logic ack);
      step(1'b0, 1'b0, 4'b0000, 1'b1, ack, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      do_reset();
      tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL reset_state got %0d want 0", state_o); end
      tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
      tests++; if (evt_layer !== 2'd0) begin fails++; $display("FAIL reset_layer got %0d want 0", evt_layer); end
      tests++; if (score_o !== 8'd0) begin fails++; $display("FAIL reset_score got %0d want 0", score_o); end
      tests++; if (game_over_o !== 1'b0) begin fails++; $display("FAIL reset_go got %0b want 0", game_over_o); end
   endtask

   task automatic test_food();
      do_reset();
      pixels(4'b0100, 3);
      frame(1'b0);
      tests++; if (state_o !== 2'b01) begin fails++; $display("FAIL food_state got %0d want 1", state_o); end
      tests++; if (evt_valid !== 1'b1) begin fails++; $display("FAIL food_valid got %0b want 1", evt_valid); end
      tests++; if (evt_layer !== 2'd2) begin fails++; $display("FAIL food_layer got %0d want 2", evt_layer); end
      tests++; if (score_o !== 8'd1) begin fails++; $display("FAIL food_score got %0d want 1", score_o); end
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
      tests++; if (state_o !== 2'b00 || evt_valid !== 1'b0) begin
         fails++; $display("FAIL food_ack got state=%0d valid=%0b want 0/0", state_o, evt_valid); end
   endtask

   task automatic test_threshold();
      do_reset();
      pixels(4'b0001, 1);
      frame(1'b0);
      tests++; if (state_o !== 2'b00 || evt_valid !== 1'b0) begin
         fails++; $display("FAIL below_min got state=%0d valid=%0b want 0/0", state_o, evt_valid); end
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      pixels(4'b0001, 2);
      frame(1'b0);
      tests++; if (state_o !== 2'b10 || game_over_o !== 1'b1 || evt_layer !== 2'd0) begin
         fails++; $display("FAIL lethal0 got state=%0d go=%0b layer=%0d want 2/1/0", state_o, game_over_o, evt_layer); end
   endtask

   task automatic test_priority();
      do_reset();
      pixels(4'b0100, 2);
      pixels(4'b1010, 2);
      frame(1'b0);
      tests++; if (state_o !== 2'b10 || evt_layer !== 2'd1 || score_o !== 8'd0) begin
         fails++; $display("FAIL priority got state=%0d layer=%0d score=%0d want 2/1/0", state_o, evt_layer, score_o); end
   endtask

   task automatic test_dead_sticky();
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
      tests++; if (evt_valid !== 1'b0 || state_o !== 2'b10 || game_over_o !== 1'b1) begin
         fails++; $display("FAIL dead_ack got valid=%0b state=%0d go=%0b want 0/2/1", evt_valid, state_o, game_over_o); end
      pixels(4'b0100, 3);
      frame(1'b0);
      tests++; if (state_o !== 2'b10 || score_o !== 8'd0 || evt_valid !== 1'b0) begin
         fails++; $display("FAIL dead_frame got state=%0d score=%0d valid=%0b want 2/0/0", state_o, score_o, evt_valid); end
   endtask

   task automatic test_eat_upgrade();
      do_reset();
      pixels(4'b0100, 2);
      frame(1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      pixels(4'b0100, 2);
      frame(1'b0);
      tests++; if (score_o !== 8'd1 || state_o !== 2'b01 || evt_layer !== 2'd2) begin
         fails++; $display("FAIL eat_ignore got score=%0d state=%0d layer=%0d want 1/1/2", score_o, state_o, evt_layer); end
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      pixels(4'b1000, 2);
      frame(1'b0);
      tests++; if (state_o !== 2'b10 || evt_layer !== 2'd3 || evt_valid !== 1'b1) begin
         fails++; $display("FAIL eat_upgrade got state=%0d layer=%0d valid=%0b want 2/3/1", state_o, evt_layer, evt_valid); end
   endtask

   task automatic test_ack_with_frame();
      do_reset();
      pixels(4'b0100, 2);
      frame(1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      pixels(4'b0100, 2);
      frame(1'b1);
      tests++; if (state_o !== 2'b01 || evt_valid !== 1'b1 || score_o !== 8'd2) begin
         fails++; $display("FAIL ack_frame got state=%0d valid=%0b score=%0d want 1/1/2", state_o, evt_valid, score_o); end
   endtask

   task automatic test_score_sat();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         pixels(4'b0100, 2);
         frame(1'b1);
      end
      tests++; if (sat_score !== 2'd3) begin fails++; $display("FAIL score_sat got %0d want 3", sat_score); end
      tests++; if (score_o !== 8'd5) begin fails++; $display("FAIL score_wide got %0d want 5", score_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      pixels(4'b0100, 2);
      frame(1'b0);
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
      frame(1'b0);
      tests++; if (state_o !== 2'b00 || evt_valid !== 1'b0 || score_o !== 8'd1) begin
         fails++; $display("FAIL back_to_back got state=%0d valid=%0b score=%0d want 0/0/1", state_o, evt_valid, score_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pixels(4'b0001, 2);
      frame(1'b0);
      do_reset();
      tests++; if ({state_o, evt_valid, evt_layer, score_o, game_over_o} !== 14'd0) begin
         fails++; $display("FAIL reset_dead got state=%0d valid=%0b layer=%0d score=%0d go=%0b want all 0",
                           state_o, evt_valid, evt_layer, score_o, game_over_o); end
      pixels(4'b0001, 1);
      do_reset();
      tests++; if ({state_o, evt_valid, evt_layer, score_o, game_over_o} !== 14'd0) begin
         fails++; $display("FAIL reset_mid got state=%0d valid=%0b want all 0", state_o, evt_valid); end
      pixels(4'b0001, 1);
      frame(1'b0);
      tests++; if (state_o !== 2'b00 || evt_valid !== 1'b0) begin
         fails++; $display("FAIL partial_discard got state=%0d valid=%0b want 0/0", state_o, evt_valid); end
   endtask

   task automatic test_random();
      int gap = 2;
      logic fe;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         fe = (gap >= 2) && ($urandom_range(0, 5) == 0);
         gap = fe ? 0 : gap + 1;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom & $urandom),
              fe, $urandom_range(0, 4) == 0, $urandom_range(0, 79) == 0);
         tests++; if (state_o !== 2'(m_mode) || evt_valid !== 1'(m_valid) || evt_layer !== 2'(m_layer)
                      || score_o !== 8'(m_score) || game_over_o !== 1'(m_go)) begin
            fails++; $display("FAIL rand_cycle%0d got st=%0d v=%0b l=%0d sc=%0d go=%0b want %0d/%0d/%0d/%0d/%0d",
                              c, state_o, evt_valid, evt_layer, score_o, game_over_o,
                              m_mode, m_valid, m_layer, m_score, m_go); end
         tests++; if (sat_score !== 2'((m_score > 3) ? 3 : m_score)) begin
            fails++; $display("FAIL rand_sat%0d got %0d want %0d", c, sat_score, (m_score > 3) ? 3 : m_score); end
      end
   endtask

   initial begin
      test_reset();
      test_food();
      test_threshold();
      test_priority();
      test_dead_sticky();
      test_eat_upgrade();
      test_ack_with_frame();
      test_score_sat();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
